module_tx_sched: RTL

MODULE_TX_SCHED -- requirements
Module: module_tx_sched

---
 rtl/txsched_pkg.sv | 13 +
 rtl/module_tx_sched_rr_arbiter.sv | 49 ++++
 rtl/module_tx_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/txsched_pkg.sv
// rtl/txsched_pkg.sv - shared types and sizes for the transmit slot scheduler
package txsched_pkg;
  localparam int NUM_REQ      = 4;
  localparam int WORD_W       = 12;
  localparam int DEF_SLOT_CYC = 156;
  localparam int DEF_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/module_tx_sched_rr_arbiter.sv
// rtl/module_tx_sched_rr_arbiter.sv - round-robin winner select with registered pointer
// TXSCHED_PRIO0_EN: req[0] preempts the rotation and leaves the pointer untouched.
module rr_arbiter
  import txsched_pkg::*;
(
  input  logic               clk_20M,
  input  logic               reset,
  input  logic               i_commit,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_cand;
  logic [PTR_W-1:0] w_win;
  logic             w_any;
  logic             w_adv;

  always_comb begin
    w_cand = r_ptr;
    w_win  = r_ptr;
    w_any  = 1'b0;
    // walk offsets high to low so the nearest requester at/above ptr survives
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = r_ptr + PTR_W'(k);
      if (i_req[w_cand]) begin
        w_win = w_cand;
        w_any = 1'b1;
      end
    end
    w_adv = w_any;
`ifdef TXSCHED_PRIO0_EN
    if (i_req[0]) begin
      w_win = '0;
      w_adv = 1'b0;
    end
`endif
    o_gnt = w_any ? (NUM_REQ'(1) << w_win) : '0;
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_commit && w_adv) begin
      r_ptr <= w_win + 1'b1;
    end
  end
endmodule

// File: rtl/module_tx_sched.sv
// rtl/module_tx_sched.sv - fixed-period frame slot scheduler feeding a serializer
// TXSCHED_PRIO0_EN selects a strict-priority requester 0 inside rr_arbiter.
module module_tx_sched
  import txsched_pkg::*;
#(
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk_20M,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WORD_W-1:0]  cmd0,
  input  logic [WORD_W-1:0]  cmd1,
  input  logic [WORD_W-1:0]  cmd2,
  input  logic [WORD_W-1:0]  cmd3,
  input  logic [WORD_W-1:0]  idle_word,
  input  logic               ser_done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               ser_start,
  output logic [WORD_W-1:0]  ser_data,
  output logic               tmo_err,
  output logic               slot_miss
);
  localparam int SC_W = $clog2(SLOT_CYC);
  localparam int TC_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [SC_W-1:0]    r_slot_cnt;
  logic [TC_W-1:0]    r_tmo_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_ser_start;
  logic [WORD_W-1:0]  r_ser_data;
  logic               r_tmo_err;
  logic               r_slot_miss;

  logic               w_slot_tick;
  logic               w_grab;
  logic               w_tmo_hit;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [WORD_W-1:0]  w_word;

  assign w_slot_tick = (r_slot_cnt == SC_W'(SLOT_CYC - 1));
  assign w_grab      = (r_state == IDLE) && w_slot_tick;
  // a ser_done in the limit cycle wins over the timeout
  assign w_tmo_hit   = (r_state == WAIT) && !ser_done && (r_tmo_cnt == TC_W'(TIMEOUT));

  rr_arbiter u_arb (
    .clk_20M  (clk_20M),
    .reset    (reset),
    .i_commit (w_grab),
    .i_req    (req),
    .o_gnt    (w_arb_gnt)
  );

  always_comb begin
    w_word = idle_word;
    case (w_arb_gnt)
      4'b0001: w_word = cmd0;
      4'b0010: w_word = cmd1;
      4'b0100: w_word = cmd2;
      4'b1000: w_word = cmd3;
      default: w_word = idle_word;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_slot_tick) w_next_state = SEND;
      SEND:    w_next_state = WAIT;
      WAIT:    if (ser_done || w_tmo_hit) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_state     <= IDLE;
      r_slot_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_gnt       <= '0;
      r_ser_start <= 1'b0;
      r_ser_data  <= '0;
      r_tmo_err   <= 1'b0;
      r_slot_miss <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_slot_cnt  <= w_slot_tick ? '0 : r_slot_cnt + 1'b1;
      r_gnt       <= w_grab ? w_arb_gnt : '0;
      r_ser_start <= w_grab;
      r_slot_miss <= w_slot_tick && (r_state != IDLE);
      if (w_grab) r_ser_data <= w_word;
      if (w_tmo_hit) r_tmo_err <= 1'b1;
      // value seen in a WAIT cycle equals cycles elapsed since SEND
      case (r_state)
        SEND:    r_tmo_cnt <= TC_W'(1);
        WAIT:    r_tmo_cnt <= r_tmo_cnt + 1'b1;
        default: r_tmo_cnt <= '0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ser_start = r_ser_start;
  assign ser_data  = r_ser_data;
  assign tmo_err   = r_tmo_err;
  assign slot_miss = r_slot_miss;
endmodule
